// File: rtl/wb_ram_pkg.sv
// Shared Wishbone B3 cycle/burst encodings and slave state type for the RAM front-ends.
package wb_ram_pkg;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiConst   = 3'b001;
    localparam logic [2:0] CtiInc     = 3'b010;
    localparam logic [2:0] CtiEob     = 3'b111;

    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

    typedef enum logic {StIdle, StBurst} state_e;

    function automatic logic cti_is_last(input logic [2:0] cti);
        return (cti == CtiClassic) || (cti == CtiEob);
    endfunction

    // Only classic, incrementing and end-of-burst cycles are served.
    function automatic logic cti_is_bad(input logic [2:0] cti);
        return !((cti == CtiClassic) || (cti == CtiInc) || (cti == CtiEob));
    endfunction

endpackage

// File: rtl/wb_ram_adr_gen.sv
// Next word address for an incrementing Wishbone burst; wrap modes only advance the low bits.
module wb_ram_adr_gen
    import wb_ram_pkg::*;
#(
    parameter int unsigned RamAw = 8
) (
    input  logic [RamAw-1:0] a_i,
    input  logic [1:0]       bte_i,
    output logic [RamAw-1:0] next_o
);

    logic [RamAw-1:0] inc;
    logic [RamAw-1:0] mask;

    always_comb begin
        inc = a_i + RamAw'(1);
        unique case (bte_i)
            BteLinear: mask = '1;
            BteWrap4:  mask = RamAw'(3);
            BteWrap8:  mask = RamAw'(7);
            BteWrap16: mask = RamAw'(15);
        endcase
        next_o = (a_i & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_ram_wbif.sv
// Wishbone B3 slave front-end for a byte-enabled 32-bit RAM with 1-cycle registered read.
module wb_ram_wbif
    import wb_ram_pkg::*;
#(
    parameter int unsigned aw    = 32,
    parameter int unsigned depth = 256,
    localparam int unsigned ram_aw = $clog2(depth)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [aw-1:0]     wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_din,
    output logic [ram_aw-1:0] ram_waddr,
    output logic [ram_aw-1:0] ram_raddr,
    input  logic [31:0]       ram_dout
);

    state_e            state_q, state_d;
    logic [ram_aw-1:0] cur_adr_q, cur_adr_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              valid, beat, last, bad;
    logic [ram_aw-1:0] word_adr;
    logic [ram_aw-1:0] adr_next;
    logic              unused_adr;

    // Upper address bits alias onto the RAM; byte offset is implied by wb_sel_i.
    assign word_adr   = wb_adr_i[ram_aw+1:2];
    assign unused_adr = ^{wb_adr_i[aw-1:ram_aw+2], wb_adr_i[1:0]};

    wb_ram_adr_gen #(
        .RamAw (ram_aw)
    ) u_adr_gen (
        .a_i    (cur_adr_q),
        .bte_i  (wb_bte_i),
        .next_o (adr_next)
    );

    always_comb begin
        valid = wb_cyc_i & wb_stb_i;
        beat  = valid & ack_q;
        last  = cti_is_last(wb_cti_i);
        bad   = cti_is_bad(wb_cti_i);

        // Dropping ack after a final beat gives the RAM a turnaround cycle.
        ack_d = valid & ~bad & ~(beat & last) & ~err_q;
        err_d = valid & bad & ~err_q;

        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        unique case (state_q)
            StIdle: begin
                if (valid && !bad && !ack_q) begin
                    cur_adr_d = word_adr;
                    if (wb_cti_i == CtiInc) state_d = StBurst;
                end
            end
            StBurst: begin
                if (beat && !bad) begin
                    if (last) state_d = StIdle;
                    else      cur_adr_d = adr_next;
                end
            end
        endcase
        if (!wb_cyc_i) state_d = StIdle;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            cur_adr_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_adr_q <= cur_adr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Read address runs one word ahead during a burst so data keeps pace with ack.
    always_comb begin
        ram_waddr = cur_adr_q;
        ram_raddr = cur_adr_q;
        unique case (state_q)
            StIdle: begin
                if (!ack_q) begin
                    ram_waddr = word_adr;
                    ram_raddr = word_adr;
                end
            end
            StBurst: begin
                if (beat) ram_raddr = adr_next;
            end
        endcase
    end

    always_comb begin
        ram_we   = wb_rst_ni ? (wb_sel_i & {4{beat & wb_we_i}}) : 4'b0000;
        ram_din  = wb_dat_i;
        wb_dat_o = ram_dout;
        wb_ack_o = ack_q;
        wb_err_o = err_q;
    end

endmodule

// File: tb/tb_wb_ram_wbif.sv
// Directed bench for wb_ram_wbif with a behavioural byte-enabled RAM behind it.
module tb_wb_ram_wbif;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err;
    logic [3:0]  ram_we;
    logic [31:0] ram_din, ram_dout;
    logic [7:0]  ram_waddr, ram_raddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_ram_wbif #(
        .aw    (32),
        .depth (256)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat_w),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_cti_i  (wb_cti),
        .wb_bte_i  (wb_bte),
        .wb_dat_o  (wb_dat_r),
        .wb_ack_o  (wb_ack),
        .wb_err_o  (wb_err),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_waddr][i*8 +: 8] <= ram_din[i*8 +: 8];
        ram_dout <= mem[ram_raddr];
    end

    // Master driver: n beats from adr, optional stb-low stall of stall_len cycles before beat stall_at.
    task automatic run_burst(input logic [31:0] adr, input logic we, input logic is_burst,
                             input logic [1:0] bte, input int n, input logic [3:0][31:0] wdat,
                             input logic [3:0] sel, input int stall_at, input int stall_len,
                             output logic [3:0][31:0] rdat, output int first_ack,
                             output int last_ack, output logic ack_at_start,
                             output int stall_acks, output logic timeout);
        int b, cyc_n, stall_left, stall_idx;
        logic stalling;
        b = 0; cyc_n = 0; stall_left = stall_len; stall_idx = 0;
        first_ack = -1; last_ack = -1; stall_acks = 0; timeout = 1'b0; rdat = '0;
        @(posedge clk); #1;
        ack_at_start = wb_ack;
        while (b < n && !timeout) begin
            stalling = (b == stall_at) && (stall_left > 0);
            wb_cyc = 1'b1;
            if (stalling) begin
                if (stall_idx > 0 && wb_ack) stall_acks++;
                stall_idx++;
                stall_left--;
                wb_stb = 1'b0;
            end else begin
                wb_stb   = 1'b1;
                wb_adr   = adr;
                wb_we    = we;
                wb_sel   = sel;
                wb_bte   = bte;
                wb_dat_w = wdat[b];
                wb_cti   = !is_burst ? 3'b000 : ((b == n - 1) ? 3'b111 : 3'b010);
                if (wb_ack) begin
                    if (first_ack < 0) first_ack = cyc_n;
                    last_ack = cyc_n;
                    rdat[b]  = wb_dat_r;
                    b++;
                end
            end
            if (b < n) begin
                @(posedge clk); #1;
                cyc_n++;
                if (cyc_n > 40) timeout = 1'b1;
            end
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = 3'b000;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] data,
                            input logic [3:0] sel, output int lat);
        logic [3:0][31:0] wd, rd;
        int la, sa;
        logic st, to;
        wd = '0; wd[0] = data;
        run_burst(adr, 1'b1, 1'b0, 2'b00, 1, wd, sel, -1, 0, rd, lat, la, st, sa, to);
        if (to) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout: adr %h got no ack, want ack", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] data,
                           output int lat, output logic ack_at_start);
        logic [3:0][31:0] rd;
        int la, sa;
        logic to;
        run_burst(adr, 1'b0, 1'b0, 2'b00, 1, '0, 4'hF, -1, 0, rd, lat, la, ack_at_start, sa, to);
        data = rd[0];
        if (to) begin
            n_vec++; n_err++;
            $display("FAIL read_timeout: adr %h got no ack, want ack", adr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
        wb_adr = 32'h0; wb_dat_w = 32'hFFFF_FFFF; wb_cti = 3'b000; wb_bte = 2'b00;
        #3;
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", wb_ack); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", wb_err); end
        n_vec++; if (ram_we !== 4'h0) begin n_err++; $display("FAIL reset_ram_we: got %h want 0", ram_we); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_classic();
        int lat; logic st; logic [31:0] d;
        wb_write(32'h10, 32'hDEAD_BEEF, 4'hF, lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL classic_wr_lat: got %0d want 1", lat); end
        wb_read(32'h10, d, lat, st);
        n_vec++; if (st !== 1'b0) begin n_err++; $display("FAIL classic_gap: ack got %b want 0", st); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL classic_rd: got %h want deadbeef", d); end
        wb_read(32'h0001_0010, d, lat, st);
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alias_rd: got %h want deadbeef", d); end
        bus_idle();
    endtask

    task automatic test_byte_write();
        int lat; logic st; logic [31:0] d;
        wb_write(32'h14, 32'h1122_3344, 4'hF, lat);
        wb_write(32'h14, 32'h0000_AA00, 4'b0010, lat);
        wb_read(32'h14, d, lat, st);
        n_vec++; if (d !== 32'h1122_AA44) begin n_err++; $display("FAIL byte_wr: got %h want 1122aa44", d); end
        bus_idle();
    endtask

    task automatic test_linear_burst();
        int lat, fa, la, sa; logic st, to;
        logic [3:0][31:0] rd;
        for (int w = 6; w < 10; w++) wb_write(w * 4, 32'h6000_0000 | w, 4'hF, lat);
        run_burst(32'h18, 1'b0, 1'b1, 2'b00, 4, '0, 4'hF, -1, 0, rd, fa, la, st, sa, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL lin_timeout: got %b want 0", to); end
        n_vec++; if (fa !== 1) begin n_err++; $display("FAIL lin_first_ack: got %0d want 1", fa); end
        n_vec++; if (la !== 4) begin n_err++; $display("FAIL lin_last_ack: got %0d want 4", la); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rd[i] !== (32'h6000_0006 + i)) begin
                n_err++; $display("FAIL lin_data%0d: got %h want %h", i, rd[i], 32'h6000_0006 + i);
            end
        end
        bus_idle();
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL lin_ack_after: got %b want 0", wb_ack); end
    endtask

    task automatic test_wrap4();
        int lat, fa, la, sa; logic st, to;
        logic [3:0][31:0] wd, rd;
        logic [31:0] d;
        logic [7:0] words [4];
        words = '{8'h0E, 8'h0F, 8'h0C, 8'h0D};
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        run_burst(32'h38, 1'b1, 1'b1, 2'b01, 4, wd, 4'hF, -1, 0, rd, fa, la, st, sa, to);
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            wb_read({22'd0, words[i], 2'b00}, d, lat, st);
            n_vec++;
            if (d !== (i + 1)) begin
                n_err++; $display("FAIL wrap4_word%h: got %h want %h", words[i], d, i + 1);
            end
        end
        bus_idle();
    endtask

    task automatic test_stall();
        int lat, fa, la, sa; logic st, to;
        logic [3:0][31:0] rd;
        for (int w = 20; w < 23; w++) wb_write(w * 4, 32'h2000_0000 | w, 4'hF, lat);
        run_burst(32'h50, 1'b0, 1'b1, 2'b00, 3, '0, 4'hF, 1, 2, rd, fa, la, st, sa, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got %b want 0", to); end
        n_vec++; if (sa !== 0) begin n_err++; $display("FAIL stall_acks: got %0d want 0", sa); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rd[i] !== (32'h2000_0014 + i)) begin
                n_err++; $display("FAIL stall_data%0d: got %h want %h", i, rd[i], 32'h2000_0014 + i);
            end
        end
        bus_idle();
    endtask

    task automatic test_err();
        int lat; logic st; logic [31:0] d;
        wb_write(32'h78, 32'h5555_AAAA, 4'hF, lat);
        bus_idle();
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
        wb_adr = 32'h78; wb_dat_w = 32'hFFFF_FFFF; wb_cti = 3'b011; wb_bte = 2'b00;
        @(posedge clk); #1;
        n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL err_pulse: got %b want 1", wb_err); end
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL err_noack: got %b want 0", wb_ack); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = 3'b000;
        @(posedge clk); #1;
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL err_drop: got %b want 0", wb_err); end
        wb_read(32'h78, d, lat, st);
        n_vec++; if (d !== 32'h5555_AAAA) begin n_err++; $display("FAIL err_ram: got %h want 5555aaaa", d); end
        bus_idle();
    endtask

    task automatic test_reset_mid_burst();
        int lat; logic st; logic [31:0] d;
        wb_write(32'h0, 32'h0BAD_F00D, 4'hF, lat);
        bus_idle();
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
        wb_adr = 32'h18; wb_cti = 3'b010; wb_bte = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (wb_ack !== 1'b1) begin n_err++; $display("FAIL rst_pre_ack: got %b want 1", wb_ack); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL rst_async_ack: got %b want 0", wb_ack); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL rst_async_err: got %b want 0", wb_err); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read(32'h0, d, lat, st);
        n_vec++; if (d !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rst_read: got %h want 0badf00d", d); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL rst_read_lat: got %0d want 1", lat); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_write();
        test_linear_burst();
        test_wrap4();
        test_stall();
        test_err();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
